// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core types and constants for the M-extension unit.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Two's-complement magnitude when the value is to be read as negative.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative RV32M multiply/divide unit (radix-2, 32 iterations).
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int               ACC_W    = 2 * XLEN;
    localparam logic [XLEN-1:0]  c_int_min = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  c_all_one = {XLEN{1'b1}};
    localparam logic [4:0]       c_last    = 5'd31;

    mdu_state_e        r_state;
    mdu_state_e        w_state_next;
    logic [4:0]        r_cnt;
    muldiv_op_e        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_opnd;
    logic [ACC_W-1:0]  r_acc;

    muldiv_op_e        w_op;
    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;

    logic [XLEN:0]     w_mul_sum;
    logic [ACC_W-1:0]  w_mul_next;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_sub;
    logic [ACC_W-1:0]  w_div_next;
    logic [ACC_W-1:0]  w_acc_next;
    logic [ACC_W-1:0]  w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    // ---------------- operand decode ----------------
    assign w_op       = muldiv_op_e'(funct3_i);
    assign w_accept   = valid_i & ~flush_i;
    assign w_a_signed = (w_op == MULH) || (w_op == MULHSU) || (w_op == DIV) || (w_op == REM);
    assign w_b_signed = (w_op == MULH) || (w_op == DIV) || (w_op == REM);
    assign w_sa       = w_a_signed & rs1_i[XLEN-1];
    assign w_sb       = w_b_signed & rs2_i[XLEN-1];
    assign w_mag_a    = abs_if(rs1_i, w_sa);
    assign w_mag_b    = abs_if(rs2_i, w_sb);

    assign w_div_zero = funct3_i[2] & (rs2_i == '0);
    assign w_ovf      = ((w_op == DIV) || (w_op == REM)) &&
                        (rs1_i == c_int_min) && (rs2_i == c_all_one);
    assign w_special  = w_div_zero | w_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = funct3_i[1] ? rs1_i : c_all_one;
        end else if (w_ovf) begin
            w_special_res = funct3_i[1] ? '0 : c_int_min;
        end
    end

    // ---------------- iteration datapath ----------------
    // Multiply: multiplier sits in the low half and shifts out LSB first.
    assign w_mul_sum  = {1'b0, r_acc[ACC_W-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: {remainder, dividend/quotient}; the shifted remainder needs XLEN+1 bits.
    assign w_div_ge   = r_acc[ACC_W-1:XLEN-1] >= {1'b0, r_opnd};
    assign w_div_sub  = r_acc[ACC_W-2:XLEN-1] - r_opnd;
    assign w_div_next = w_div_ge ? {w_div_sub, r_acc[XLEN-2:0], 1'b1}
                                 : {r_acc[ACC_W-2:0], 1'b0};

    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;

    assign w_prod = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_quot = r_neg_q ? (~w_acc_next[XLEN-1:0] + 1'b1) : w_acc_next[XLEN-1:0];
    assign w_rem  = r_neg_r ? (~w_acc_next[ACC_W-1:XLEN] + 1'b1) : w_acc_next[ACC_W-1:XLEN];

    always_comb begin
        w_final = '0;
        if (r_op[2]) begin
            w_final = r_op[1] ? w_rem : w_quot;
        end else if (r_op == MUL) begin
            w_final = w_prod[XLEN-1:0];
        end else begin
            w_final = w_prod[ACC_W-1:XLEN];
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        stall_o      = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    stall_o      = 1'b1;
                    w_state_next = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                stall_o = 1'b1;
                if (r_cnt == c_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done_o       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        // A kill beats everything; the killed op must not be seen as done.
        if (flush_i) begin
            w_state_next = IDLE;
            done_o       = 1'b0;
        end
        if (rst) begin
            stall_o = 1'b0;
            done_o  = 1'b0;
        end
    end

    // ---------------- operand / accumulator / result registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= MUL;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            result_o <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_op    <= w_op;
                        r_neg_q <= w_sa ^ w_sb;
                        r_neg_r <= w_sa;
                        if (funct3_i[2]) begin
                            r_opnd <= w_mag_b;
                            r_acc  <= {{XLEN{1'b0}}, w_mag_a};
                        end else begin
                            r_opnd <= w_mag_a;
                            r_acc  <= {{XLEN{1'b0}}, w_mag_b};
                        end
                        if (w_special) begin
                            result_o <= w_special_res;
                        end
                    end
                end
                CALC: begin
                    if (!flush_i) begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == c_last) begin
                            result_o <= w_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Directed self-checking bench for ex_muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;
    import core_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int n_checks;
    int n_errors;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_i  = 1'b1;
        funct3_i = op;
        rs1_i    = a;
        rs2_i    = b;
    endtask

    // Samples cycles T, T+1, ... on the falling edge until done_o, then retires the op.
    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
        int          done_at;
        int          stall_cnt;
        logic [31:0] res;
        done_at   = -1;
        stall_cnt = 0;
        res       = '0;
        for (int k = 0; k <= 40 && done_at < 0; k++) begin
            @(negedge clk);
            if (stall_o) stall_cnt++;
            if (done_o) begin
                done_at = k;
                res     = result_o;
            end
        end
        check({tag, " latency"}, done_at, exp_lat);
        check({tag, " stall cycles"}, stall_cnt, exp_lat);
        check({tag, " result"}, res, exp_res);
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        check({tag, " done single pulse"}, {31'b0, done_o}, 32'd0);
        check({tag, " result held"}, result_o, exp_res);
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        @(posedge clk);
        #1 start(op, a, b);
        wait_done(tag, exp_lat, exp_res);
    endtask

    initial begin
        int d;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        valid_i  = 1'b0;
        funct3_i = 3'b000;
        rs1_i    = '0;
        rs2_i    = '0;
        flush_i  = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset stall", {31'b0, stall_o}, 32'd0);
        check("reset done", {31'b0, done_o}, 32'd0);
        check("reset result", result_o, 32'd0);

        // Special cases: one-cycle stall, done on the next cycle.
        do_op("DIV 5/0",        DIV,  32'd5,        32'd0,        1, 32'hFFFF_FFFF);
        do_op("REMU 5/0",       REMU, 32'd5,        32'd0,        1, 32'd5);
        do_op("DIV ovf",        DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        do_op("REM ovf",        REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

        // Iterative operations: 33-cycle stall, done at T+33.
        do_op("MUL 7*-3",       MUL,    32'd7,         32'hFFFF_FFFD, 33, 32'hFFFF_FFEB);
        do_op("MULH min*min",   MULH,   32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000);
        do_op("MULHU max*max",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
        do_op("MULHSU -1*max",  MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF);
        do_op("DIV -7/2",       DIV,    32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD);
        do_op("REM -7/2",       REM,    32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF);
        do_op("DIVU 100/7",     DIVU,   32'd100,       32'd7,         33, 32'd14);
        do_op("REMU 100/7",     REMU,   32'd100,       32'd7,         33, 32'd2);

        // Flush at T+10 of a DIV, then a new MUL accepted at T+11.
        d = 0;
        @(posedge clk);
        #1 start(DIV, 32'd100, 32'd7);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_o) d++;
        end
        @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        if (done_o) d++;
        @(posedge clk);
        #1 begin
            flush_i = 1'b0;
            valid_i = 1'b0;
        end
        #1;
        check("flush stall released", {31'b0, stall_o}, 32'd0);
        check("flush no done", d + {31'b0, done_o}, 32'd0);
        check("flush result kept", result_o, 32'd2);
        #1 start(MUL, 32'd3, 32'd4);
        wait_done("MUL 3*4 after flush", 33, 32'd12);

        // Reset at T+20 of a MUL, then a normal DIVU.
        @(posedge clk);
        #1 start(MUL, 32'd5, 32'd6);
        for (int k = 0; k < 20; k++) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst forces stall low", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1 begin
            rst     = 1'b0;
            valid_i = 1'b0;
        end
        #1;
        check("rst mid-op done", {31'b0, done_o}, 32'd0);
        check("rst mid-op stall", {31'b0, stall_o}, 32'd0);
        check("rst mid-op result", result_o, 32'd0);
        do_op("DIVU 9/3 after rst", DIVU, 32'd9, 32'd3, 33, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, upstream of the memory stage. On an M-extension instruction it stalls the front end, computes the result over 32 iteration cycles, and presents it for capture into the EX/MEM pipeline register in place of the ALU result. One operation is in flight at a time; a flush kills it.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- valid_i  in  1  EX holds an M-extension op (opcode OP, funct7 0000001).
- funct3_i  in  3  operation select (muldiv_op_e encoding).
- rs1_i  in  32  operand A (forwarded value).
- rs2_i  in  32  operand B (forwarded value).
- flush_i  in  1  kill any in-flight or pending op (branch redirect).
- stall_o  out  1  hold PC, IF/ID and ID/EX; insert a bubble into EX/MEM.
- done_o  out  1  one-cycle pulse: result_o is valid and the EX/MEM register captures it.
- result_o  out  32  result, registered; held until the next done.

## Operation
- FSM states:
  - IDLE: accepts new ops.
  - CALC: one radix-2 iteration per cycle; 5-bit counter.
  - DONE: presents the result.
- IDLE, valid_i=1, flush_i=0:
  - Latch |A|, |B|, the sign flags and funct3.
  - Special case (divisor 0, or DIV/REM with 0x80000000 and -1): write the fixed result to result_o and go to DONE.
  - Otherwise clear the counter and go to CALC.
- Multiply (MUL, MULH, MULHSU, MULHU):
  - Shift-add on a 64-bit accumulator using unsigned magnitudes.
  - Signedness: MULH treats A and B as signed; MULHSU treats A signed, B unsigned; MULHU treats both unsigned.
  - Negate the 64-bit product when the operand signs differ.
  - MUL returns product[31:0]; all others return product[63:32].
- Divide (DIV, DIVU, REM, REMU):
  - Restoring division on magnitudes.
  - Quotient is negated when the signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
- Fixed results:
  - DIV or DIVU by 0 → 0xFFFFFFFF.
  - REM or REMU by 0 → dividend.
  - DIV 0x80000000 / -1 → 0x80000000.
  - REM 0x80000000 / -1 → 0.
- CALC: the counter increments each cycle. At count 31 the final sign correction is written to result_o and the FSM goes to DONE.
- DONE: done_o=1 and stall_o=0, so the held instruction advances with result_o. Next state is IDLE unconditionally; the same instruction is never re-accepted.
- stall_o = (IDLE & valid_i & ~flush_i) | CALC. It is combinational and forced to 0 during rst.
- flush_i has priority in every state:
  - The next state is IDLE.
  - done_o does not pulse for the killed op.
  - result_o is unchanged.
- Arithmetic is modulo 2^32 at the output. Magnitude of 0x80000000 is 0x80000000 as unsigned.

## Timing
- Reset values: FSM IDLE; done_o=0; result_o=0; stall_o=0; counter 0.
- Normal op, accepted at cycle T:
  - T: stall_o=1.
  - T+1..T+32: CALC, stall_o=1.
  - T+33: DONE, done_o=1, stall_o=0.
  - Stall lasts exactly 33 cycles; latency from accept to done_o is 33 cycles.
- Special case accepted at T: done_o at T+1; stall_o high for T only.
- Back-to-back M ops: the second is seen in IDLE at T+34 (the cycle after DONE). Minimum spacing between accepts is 34 cycles.
- flush_i at cycle F: state is IDLE at F+1 and stall_o=0 at F+1 unless a new valid op is present. In IDLE, flush_i suppresses the combinational stall in the same cycle.
- rst mid-operation: IDLE on the next edge. No done_o pulse; result_o=0.

## Structure
- core_pkg additions:
  - muldiv_op_e: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - mdu_state_e: IDLE, CALC, DONE.
  - FUNCT7_MULDIV = 7'b0000001.
- Single module; no sub-module. Multiply and divide share the 64-bit accumulator and the counter.
- The EX stage muxes result_o over alu_result when the instruction is M-type.

## Test plan
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB. stall_o high cycles T..T+32; done_o only at T+33.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- Special cases, each with done_o at T+1:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- flush_i at T+10 of a DIV: no done_o; stall_o=0 at T+11; result_o keeps its previous value. A new MUL 3×4 at T+11 → 12 at T+44.
- rst at T+20 of a MUL: outputs return to 0 on the next edge. A subsequent DIVU 9/3 → 3 with normal 33-cycle timing.
